// File: rtl/latch_wr_sched.sv
// latch_wr_sched: round-robin write scheduler for a shared bank of DW-wide
// level-sensitive latches. It arbitrates requesters, captures the winner's
// data, then walks the latch gate through SETUP/OPEN/HOLD phases so lat_d is
// stable around both gate edges.
// Optional build macro: LATCH_WR_PRIO0_EN gives requester 0 absolute priority
// and leaves the round-robin pointer untouched when it wins.
module latch_wr_sched #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        lat_d,
    output logic                 lat_en,
    output logic                 busy
);

    localparam int PW    = $clog2(NREQ);
    localparam int MAXC0 = (SETUP_CYC > OPEN_CYC) ? SETUP_CYC : OPEN_CYC;
    localparam int MAXC  = (MAXC0 > HOLD_CYC) ? MAXC0 : HOLD_CYC;
    // A phase of one cycle still needs a 1-bit counter to exist.
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [PW-1:0]            rr_ptr;
    logic [NREQ-1:0][DW-1:0]  wdata_a;
    logic [NREQ-1:0]          req_m;
    logic [PW:0]              cand;
    logic                     win_vld;
    logic [PW-1:0]            win_idx;
    logic [PW-1:0]            nxt_ptr;

    assign wdata_a = wdata;

    // Winner search: first set request from rr_ptr upward, wrapping at NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        req_m   = req;
`ifdef LATCH_WR_PRIO0_EN
        req_m[0] = 1'b0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(NREQ))
                cand = cand - (PW+1)'(NREQ);
            if (!win_vld && req_m[cand[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
        nxt_ptr = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + PW'(1);
`ifdef LATCH_WR_PRIO0_EN
        // Requester 0 overrides rotation and does not consume a turn.
        if (req[0]) begin
            win_vld = 1'b1;
            win_idx = '0;
            nxt_ptr = rr_ptr;
        end
`endif
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            gnt    <= '0;
            done   <= '0;
            lat_d  <= '0;
            lat_en <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state  <= SETUP;
                        gnt    <= NREQ'(1) << win_idx;
                        lat_d  <= wdata_a[win_idx];
                        busy   <= 1'b1;
                        rr_ptr <= nxt_ptr;
                        cnt    <= CW'(SETUP_CYC-1);
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state  <= OPEN;
                        lat_en <= 1'b1;
                        cnt    <= CW'(OPEN_CYC-1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                OPEN: begin
                    if (cnt == '0) begin
                        state  <= HOLD;
                        lat_en <= 1'b0;
                        cnt    <= CW'(HOLD_CYC-1);
                        // A single-cycle HOLD is also the final HOLD cycle.
                        if (HOLD_CYC == 1)
                            done <= gnt;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        gnt   <= '0;
                        done  <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            done <= gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
